// File: rtl/ewb_control.sv
// ---------------------------------------------------------------------------
// ewb_control
//
// Control FSM for the eviction write buffer (EWB). It sits between the L1
// miss port (cpu side) and the L2 / memory port (mem side). It accepts one
// dirty-line writeback with a zero-wait ack and drains that line to memory
// later. It also keeps reads of the buffered line ordered behind its drain.
//
// Handshakes:
//   cpu_read / cpu_write are held by upstream until cpu_resp pulses for one
//   cycle. mem_read / mem_write are held by this block, with datamux_sel
//   stable, until mem_resp pulses for one cycle. A mem_resp that arrives
//   while no strobe is up is ignored.
//
// Ports:
//   clk, reset       clock; synchronous active-high reset
//   cpu_read         upstream line-read request
//   cpu_write        upstream line-writeback request
//   cpu_addr[15:0]   upstream request address
//   cpu_resp         one-cycle completion pulse to upstream
//   mem_read         downstream read strobe
//   mem_write        downstream write strobe
//   mem_resp         downstream completion pulse
//   load_data        datapath: capture cpu data/address into buffer this edge
//   datamux_sel      datapath: 0 = pass-through cpu side, 1 = buffered line
//   buf_valid        buffer holds an undrained line
// ---------------------------------------------------------------------------
module ewb_control #(
    parameter int unsigned IDLE_DRAIN_CYCLES = 4,
    parameter int unsigned LINE_OFFSET_BITS  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_read,
    input  logic        cpu_write,
    input  logic [15:0] cpu_addr,
    output logic        cpu_resp,
    output logic        mem_read,
    output logic        mem_write,
    input  logic        mem_resp,
    output logic        load_data,
    output logic        datamux_sel,
    output logic        buf_valid
);

    localparam int unsigned TAG_W = 16 - LINE_OFFSET_BITS;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FULL  = 2'd1;
    localparam logic [1:0] S_READ  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    // The idle count is compared before it is incremented. With the default
    // of 4 the drain strobe therefore rises on the fifth idle cycle in FULL.
    localparam logic [7:0] CNT_LAST = 8'(IDLE_DRAIN_CYCLES - 1);

    logic [1:0]       state, state_next;
    logic             valid, valid_next;
    logic [TAG_W-1:0] tag;
    logic [7:0]       idle_cnt, idle_cnt_next;
    logic             hit;

    assign hit = (cpu_addr[15:LINE_OFFSET_BITS] == tag);

    always_comb begin
        state_next    = state;
        valid_next    = valid;
        idle_cnt_next = idle_cnt;
        cpu_resp      = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        load_data     = 1'b0;
        datamux_sel   = 1'b0;

        case (state)
            S_IDLE: begin
                // Read wins if upstream illegally raises both requests.
                if (cpu_read) begin
                    state_next = S_READ;
                end else if (cpu_write) begin
                    load_data     = 1'b1;
                    cpu_resp      = 1'b1;
                    valid_next    = 1'b1;
                    idle_cnt_next = 8'd0;
                    state_next    = S_FULL;
                end
            end
            S_FULL: begin
                if (cpu_read || cpu_write) begin
                    idle_cnt_next = 8'd0;
                    // A read of a different line may bypass the buffered
                    // line. A read of the same line, or a second writeback,
                    // must wait for the drain to finish.
                    if (cpu_read && !hit) begin
                        state_next = S_READ;
                    end else begin
                        state_next = S_DRAIN;
                    end
                end else if (idle_cnt == CNT_LAST) begin
                    state_next = S_DRAIN;
                end else begin
                    idle_cnt_next = idle_cnt + 8'd1;
                end
            end
            S_READ: begin
                mem_read = 1'b1;
                cpu_resp = mem_resp;
                if (mem_resp) begin
                    state_next = valid ? S_FULL : S_IDLE;
                end
            end
            default: begin // S_DRAIN
                mem_write   = 1'b1;
                datamux_sel = 1'b1;
                if (mem_resp) begin
                    valid_next    = 1'b0;
                    idle_cnt_next = 8'd0;
                    state_next    = S_IDLE;
                end
            end
        endcase

        // Keep every output quiet while reset is sampled.
        if (reset) begin
            cpu_resp    = 1'b0;
            mem_read    = 1'b0;
            mem_write   = 1'b0;
            load_data   = 1'b0;
            datamux_sel = 1'b0;
        end
    end

    assign buf_valid = valid & ~reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            valid    <= 1'b0;
            tag      <= '0;
            idle_cnt <= 8'd0;
        end else begin
            state    <= state_next;
            valid    <= valid_next;
            idle_cnt <= idle_cnt_next;
            if (load_data) begin
                tag <= cpu_addr[15:LINE_OFFSET_BITS];
            end
        end
    end

endmodule
